// File: rtl/bru_iq_gen_if.sv
// Issue-queue bundle: dispatch write ports, writeback wakeup, kill/age reference, and issue/PRF-read outputs.
// The master side is the dispatcher/core; the slave side is the issue queue itself.
interface bru_iq_gen_if #(
  parameter int IQ_ENTRIES         = 4,
  parameter int PAYLOAD_W          = 100,
  parameter int LOG_PR_COUNT       = 7,
  parameter int LOG_ROB_ENTRIES    = 5,
  parameter int PRF_BANK_COUNT     = 4,
  parameter int LOG_PRF_BANK_COUNT = 2
);
  localparam int UPPER_W = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

  logic [IQ_ENTRIES-1:0]                      dispatch_valid_by_entry;
  logic [IQ_ENTRIES-1:0][PAYLOAD_W-1:0]       dispatch_payload_by_entry;
  logic [IQ_ENTRIES-1:0][LOG_PR_COUNT-1:0]    dispatch_A_PR_by_entry;
  logic [IQ_ENTRIES-1:0]                      dispatch_A_unneeded_by_entry;
  logic [IQ_ENTRIES-1:0]                      dispatch_A_ready_by_entry;
  logic [IQ_ENTRIES-1:0][LOG_PR_COUNT-1:0]    dispatch_B_PR_by_entry;
  logic [IQ_ENTRIES-1:0]                      dispatch_B_unneeded_by_entry;
  logic [IQ_ENTRIES-1:0]                      dispatch_B_ready_by_entry;
  logic [IQ_ENTRIES-1:0][LOG_PR_COUNT-1:0]    dispatch_dest_PR_by_entry;
  logic [IQ_ENTRIES-1:0][LOG_ROB_ENTRIES-1:0] dispatch_ROB_index_by_entry;
  logic [IQ_ENTRIES-1:0]                      dispatch_open_by_entry;

  logic                                       pipeline_ready;
  logic [PRF_BANK_COUNT-1:0]                  WB_bus_valid_by_bank;
  logic [PRF_BANK_COUNT-1:0][UPPER_W-1:0]     WB_bus_upper_PR_by_bank;
  logic                                       kill_valid;
  logic [LOG_ROB_ENTRIES-1:0]                 kill_ROB_index;
  logic [LOG_ROB_ENTRIES-1:0]                 ROB_head_index;

  logic                                       issue_valid;
  logic [PAYLOAD_W-1:0]                       issue_payload;
  logic                                       issue_A_unneeded;
  logic                                       issue_A_forward;
  logic [LOG_PRF_BANK_COUNT-1:0]              issue_A_bank;
  logic                                       issue_B_unneeded;
  logic                                       issue_B_forward;
  logic [LOG_PRF_BANK_COUNT-1:0]              issue_B_bank;
  logic [LOG_PR_COUNT-1:0]                    issue_dest_PR;
  logic [LOG_ROB_ENTRIES-1:0]                 issue_ROB_index;
  logic                                       PRF_req_A_valid;
  logic [LOG_PR_COUNT-1:0]                    PRF_req_A_PR;
  logic                                       PRF_req_B_valid;
  logic [LOG_PR_COUNT-1:0]                    PRF_req_B_PR;

  modport master (
    output dispatch_valid_by_entry, dispatch_payload_by_entry,
           dispatch_A_PR_by_entry, dispatch_A_unneeded_by_entry, dispatch_A_ready_by_entry,
           dispatch_B_PR_by_entry, dispatch_B_unneeded_by_entry, dispatch_B_ready_by_entry,
           dispatch_dest_PR_by_entry, dispatch_ROB_index_by_entry,
           pipeline_ready, WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank,
           kill_valid, kill_ROB_index, ROB_head_index,
    input  dispatch_open_by_entry,
           issue_valid, issue_payload, issue_A_unneeded, issue_A_forward, issue_A_bank,
           issue_B_unneeded, issue_B_forward, issue_B_bank, issue_dest_PR, issue_ROB_index,
           PRF_req_A_valid, PRF_req_A_PR, PRF_req_B_valid, PRF_req_B_PR
  );

  modport slave (
    input  dispatch_valid_by_entry, dispatch_payload_by_entry,
           dispatch_A_PR_by_entry, dispatch_A_unneeded_by_entry, dispatch_A_ready_by_entry,
           dispatch_B_PR_by_entry, dispatch_B_unneeded_by_entry, dispatch_B_ready_by_entry,
           dispatch_dest_PR_by_entry, dispatch_ROB_index_by_entry,
           pipeline_ready, WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank,
           kill_valid, kill_ROB_index, ROB_head_index,
    output dispatch_open_by_entry,
           issue_valid, issue_payload, issue_A_unneeded, issue_A_forward, issue_A_bank,
           issue_B_unneeded, issue_B_forward, issue_B_bank, issue_dest_PR, issue_ROB_index,
           PRF_req_A_valid, PRF_req_A_PR, PRF_req_B_valid, PRF_req_B_PR
  );
endinterface

// File: rtl/bru_iq_gen.sv
// Collapsing age-ordered issue queue (entry 0 oldest): issues the oldest ready op combinationally from state, stalls on
// ~pipeline_ready, wakes operands from the WB bus, kills ROB-younger ops; IQ_OCCUPANCY_EN adds a registered occupancy count.
module bru_iq_gen #(
  parameter int IQ_ENTRIES         = 4,
  parameter int PAYLOAD_W          = 100,
  parameter int LOG_PR_COUNT       = 7,
  parameter int LOG_ROB_ENTRIES    = 5,
  parameter int LOG_PRF_BANK_COUNT = 2
) (
  input  logic CLK,
  input  logic nRST,
  bru_iq_gen_if.slave bus
`ifdef IQ_OCCUPANCY_EN
  ,
  output logic [$clog2(IQ_ENTRIES+1)-1:0] occupancy
`endif
);
  localparam int IDX_W = $clog2(IQ_ENTRIES);
  localparam int LPR   = LOG_PR_COUNT;
  localparam int LROB  = LOG_ROB_ENTRIES;
  localparam int LB    = LOG_PRF_BANK_COUNT;

  logic [IQ_ENTRIES-1:0]                 r_valid, r_A_unneeded, r_A_ready, r_B_unneeded, r_B_ready;
  logic [IQ_ENTRIES-1:0][PAYLOAD_W-1:0]  r_payload;
  logic [IQ_ENTRIES-1:0][LPR-1:0]        r_A_PR, r_B_PR, r_dest_PR;
  logic [IQ_ENTRIES-1:0][LROB-1:0]       r_ROB_index;

  logic [IQ_ENTRIES-1:0]                 w_nxt_valid, w_nxt_A_unneeded, w_nxt_A_ready, w_nxt_B_unneeded, w_nxt_B_ready;
  logic [IQ_ENTRIES-1:0][PAYLOAD_W-1:0]  w_nxt_payload, w_up_payload;
  logic [IQ_ENTRIES-1:0][LPR-1:0]        w_nxt_A_PR, w_nxt_B_PR, w_nxt_dest_PR;
  logic [IQ_ENTRIES-1:0][LPR-1:0]        w_up_A_PR, w_up_B_PR, w_up_dest_PR;
  logic [IQ_ENTRIES-1:0][LROB-1:0]       w_nxt_ROB_index, w_up_ROB_index, w_entry_age;

  logic [IQ_ENTRIES-1:0] w_A_forward, w_B_forward, w_kill_mask, w_eff_valid, w_ready;
  logic [IQ_ENTRIES-1:0] w_issue_mask, w_shift, w_hold;
  logic [IQ_ENTRIES-1:0] w_A_rdy_upd, w_B_rdy_upd;
  logic [IQ_ENTRIES-1:0] w_valid_up, w_eff_up, w_A_un_up, w_B_un_up, w_A_rdy_up, w_B_rdy_up;
  logic [LROB-1:0]       w_kill_age;
  logic [IDX_W-1:0]      w_issue_idx;
  logic                  w_issue_found;

  // Wakeup, head-relative kill age and per-entry readiness.
  always_comb begin
    w_A_forward = '0;
    w_B_forward = '0;
    w_kill_mask = '0;
    w_ready     = '0;
    w_entry_age = '0;
    w_kill_age  = bus.kill_ROB_index - bus.ROB_head_index;
    for (int i = 0; i < IQ_ENTRIES; i++) begin
      w_A_forward[i] = bus.WB_bus_valid_by_bank[r_A_PR[i][LB-1:0]] &
                       (bus.WB_bus_upper_PR_by_bank[r_A_PR[i][LB-1:0]] == r_A_PR[i][LPR-1:LB]);
      w_B_forward[i] = bus.WB_bus_valid_by_bank[r_B_PR[i][LB-1:0]] &
                       (bus.WB_bus_upper_PR_by_bank[r_B_PR[i][LB-1:0]] == r_B_PR[i][LPR-1:LB]);
      w_entry_age[i] = r_ROB_index[i] - bus.ROB_head_index;
      w_kill_mask[i] = bus.kill_valid & r_valid[i] & (w_entry_age[i] > w_kill_age);
      w_ready[i]     = bus.pipeline_ready & r_valid[i] & ~w_kill_mask[i] &
                       (r_A_unneeded[i] | r_A_ready[i] | w_A_forward[i]) &
                       (r_B_unneeded[i] | r_B_ready[i] | w_B_forward[i]);
    end
  end

  assign w_eff_valid = r_valid & ~w_kill_mask;
  assign w_A_rdy_upd = r_A_ready | w_A_forward;
  assign w_B_rdy_upd = r_B_ready | w_B_forward;

  always_comb begin
    w_issue_found = 1'b0;
    w_issue_idx   = '0;
    for (int i = IQ_ENTRIES - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_issue_found = 1'b1;
        w_issue_idx   = IDX_W'(i);
      end
    end
    w_issue_mask = '0;
    for (int i = 0; i < IQ_ENTRIES; i++) begin
      w_issue_mask[i] = w_issue_found & (IDX_W'(i) >= w_issue_idx);
    end
  end

  assign bus.issue_valid      = w_issue_found;
  assign bus.issue_payload    = r_payload[w_issue_idx];
  assign bus.issue_A_unneeded = r_A_unneeded[w_issue_idx];
  assign bus.issue_A_forward  = w_A_forward[w_issue_idx];
  assign bus.issue_A_bank     = r_A_PR[w_issue_idx][LB-1:0];
  assign bus.issue_B_unneeded = r_B_unneeded[w_issue_idx];
  assign bus.issue_B_forward  = w_B_forward[w_issue_idx];
  assign bus.issue_B_bank     = r_B_PR[w_issue_idx][LB-1:0];
  assign bus.issue_dest_PR    = r_dest_PR[w_issue_idx];
  assign bus.issue_ROB_index  = r_ROB_index[w_issue_idx];
  // Forwarded operands come off the bypass network, so no PRF read for them.
  assign bus.PRF_req_A_valid  = w_issue_found & ~r_A_unneeded[w_issue_idx] & ~w_A_forward[w_issue_idx];
  assign bus.PRF_req_A_PR     = r_A_PR[w_issue_idx];
  assign bus.PRF_req_B_valid  = w_issue_found & ~r_B_unneeded[w_issue_idx] & ~w_B_forward[w_issue_idx];
  assign bus.PRF_req_B_PR     = r_B_PR[w_issue_idx];

  // Views of entry i+1 as seen from entry i; the top entry sees an empty slot.
  assign w_valid_up = {1'b0, r_valid[IQ_ENTRIES-1:1]};
  assign w_eff_up   = {1'b0, w_eff_valid[IQ_ENTRIES-1:1]};
  assign w_A_un_up  = {1'b0, r_A_unneeded[IQ_ENTRIES-1:1]};
  assign w_B_un_up  = {1'b0, r_B_unneeded[IQ_ENTRIES-1:1]};
  assign w_A_rdy_up = {1'b0, w_A_rdy_upd[IQ_ENTRIES-1:1]};
  assign w_B_rdy_up = {1'b0, w_B_rdy_upd[IQ_ENTRIES-1:1]};

  always_comb begin
    w_up_payload   = '0;
    w_up_A_PR      = '0;
    w_up_B_PR      = '0;
    w_up_dest_PR   = '0;
    w_up_ROB_index = '0;
    for (int i = 0; i < IQ_ENTRIES - 1; i++) begin
      w_up_payload[i]   = r_payload[i+1];
      w_up_A_PR[i]      = r_A_PR[i+1];
      w_up_B_PR[i]      = r_B_PR[i+1];
      w_up_dest_PR[i]   = r_dest_PR[i+1];
      w_up_ROB_index[i] = r_ROB_index[i+1];
    end
  end

  // An issuing slot with nothing above it behaves as empty, so it can take a dispatch directly.
  assign w_shift = w_issue_mask & w_valid_up;
  assign w_hold  = w_eff_valid & ~w_issue_mask;
  assign bus.dispatch_open_by_entry = {IQ_ENTRIES{~bus.kill_valid}} & ~w_shift & ~(r_valid & ~w_issue_mask);

  always_comb begin
    w_nxt_valid      = '0;
    w_nxt_payload    = r_payload;
    w_nxt_A_PR       = r_A_PR;
    w_nxt_A_unneeded = r_A_unneeded;
    w_nxt_A_ready    = r_A_ready;
    w_nxt_B_PR       = r_B_PR;
    w_nxt_B_unneeded = r_B_unneeded;
    w_nxt_B_ready    = r_B_ready;
    w_nxt_dest_PR    = r_dest_PR;
    w_nxt_ROB_index  = r_ROB_index;
    for (int i = 0; i < IQ_ENTRIES; i++) begin
      if (w_shift[i]) begin
        w_nxt_valid[i]      = w_eff_up[i];
        w_nxt_payload[i]    = w_up_payload[i];
        w_nxt_A_PR[i]       = w_up_A_PR[i];
        w_nxt_A_unneeded[i] = w_A_un_up[i];
        w_nxt_A_ready[i]    = w_A_rdy_up[i];
        w_nxt_B_PR[i]       = w_up_B_PR[i];
        w_nxt_B_unneeded[i] = w_B_un_up[i];
        w_nxt_B_ready[i]    = w_B_rdy_up[i];
        w_nxt_dest_PR[i]    = w_up_dest_PR[i];
        w_nxt_ROB_index[i]  = w_up_ROB_index[i];
      end else if (w_hold[i]) begin
        w_nxt_valid[i]   = 1'b1;
        w_nxt_A_ready[i] = w_A_rdy_upd[i];
        w_nxt_B_ready[i] = w_B_rdy_upd[i];
      end else begin
        w_nxt_valid[i] = bus.dispatch_valid_by_entry[i] & ~bus.kill_valid;
        if (bus.dispatch_valid_by_entry[i]) begin
          w_nxt_payload[i]    = bus.dispatch_payload_by_entry[i];
          w_nxt_A_PR[i]       = bus.dispatch_A_PR_by_entry[i];
          w_nxt_A_unneeded[i] = bus.dispatch_A_unneeded_by_entry[i];
          w_nxt_A_ready[i]    = bus.dispatch_A_ready_by_entry[i];
          w_nxt_B_PR[i]       = bus.dispatch_B_PR_by_entry[i];
          w_nxt_B_unneeded[i] = bus.dispatch_B_unneeded_by_entry[i];
          w_nxt_B_ready[i]    = bus.dispatch_B_ready_by_entry[i];
          w_nxt_dest_PR[i]    = bus.dispatch_dest_PR_by_entry[i];
          w_nxt_ROB_index[i]  = bus.dispatch_ROB_index_by_entry[i];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid      <= '0;
      r_payload    <= '0;
      r_A_PR       <= '0;
      r_A_unneeded <= '0;
      r_A_ready    <= '0;
      r_B_PR       <= '0;
      r_B_unneeded <= '0;
      r_B_ready    <= '0;
      r_dest_PR    <= '0;
      r_ROB_index  <= '0;
    end else begin
      r_valid      <= w_nxt_valid;
      r_payload    <= w_nxt_payload;
      r_A_PR       <= w_nxt_A_PR;
      r_A_unneeded <= w_nxt_A_unneeded;
      r_A_ready    <= w_nxt_A_ready;
      r_B_PR       <= w_nxt_B_PR;
      r_B_unneeded <= w_nxt_B_unneeded;
      r_B_ready    <= w_nxt_B_ready;
      r_dest_PR    <= w_nxt_dest_PR;
      r_ROB_index  <= w_nxt_ROB_index;
    end
  end

`ifdef IQ_OCCUPANCY_EN
  localparam int OCC_W = $clog2(IQ_ENTRIES + 1);
  logic [OCC_W-1:0] w_occ_nxt;

  always_comb begin
    w_occ_nxt = '0;
    for (int i = 0; i < IQ_ENTRIES; i++) begin
      w_occ_nxt = w_occ_nxt + OCC_W'(w_nxt_valid[i]);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      occupancy <= '0;
    end else begin
      occupancy <= w_occ_nxt;
    end
  end
`endif
endmodule
